// File: rtl/vga_mon_pkg.sv
// Shared definitions for the VGA timing monitor: default 800x600@60 mode
// geometry, FSM state encoding and the CRC-16-CCITT constants/step function.
package vga_mon_pkg;

  localparam int MODE_H_TOTAL  = 1056;
  localparam int MODE_H_SYNC   = 128;
  localparam int MODE_H_BP     = 88;
  localparam int MODE_H_ACTIVE = 800;
  localparam int MODE_V_TOTAL  = 628;
  localparam int MODE_V_SYNC   = 4;
  localparam int MODE_V_BP     = 23;
  localparam int MODE_V_ACTIVE = 600;
  localparam int MODE_CW       = 11;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  // One pixel of CRC-16-CCITT over 12 data bits, MSB first.
  function automatic logic [15:0] crc16_12(input logic [15:0] crc, input logic [11:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_mon_edge.sv
// Two-flop input register for one sync line, normalised to active-high,
// with single-cycle rise/fall pulses on the normalised level.
module vga_mon_edge
  import vga_mon_pkg::*;
#(
  parameter bit POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;
  logic norm;

  // Flops reset to the inactive line level so release never fakes an edge.
  assign norm = s2_q ^ ~POL;

  // Input register pair plus previous normalised level for edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= ~POL;
      s2_q   <= ~POL;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sig_i;
      s2_q   <= s1_q;
      prev_q <= norm;
    end
  end

  assign rise_o = norm & ~prev_q;
  assign fall_o = ~norm & prev_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures line/frame geometry, recovers
// pixel coordinates and data-enable, and tracks lock against the mode.
// Optional per-frame CRC-16 over active pixels: define VGA_MON_CRC_EN.
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_TOTAL  = MODE_H_TOTAL,
  parameter int H_SYNC   = MODE_H_SYNC,
  parameter int H_BP     = MODE_H_BP,
  parameter int H_ACTIVE = MODE_H_ACTIVE,
  parameter int V_TOTAL  = MODE_V_TOTAL,
  parameter int V_SYNC   = MODE_V_SYNC,
  parameter int V_BP     = MODE_V_BP,
  parameter int V_ACTIVE = MODE_V_ACTIVE,
  parameter bit SYNC_POL = 1'b1,
  parameter int CW       = MODE_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs,
  input  logic          vs,
  input  logic [3:0]    r,
  input  logic [3:0]    g,
  input  logic [3:0]    b,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_sync_w,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_sync_w,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          de,
  output logic          frame_start,
  output logic          locked,
  output logic [7:0]    err_count,
  output logic [15:0]   frame_crc
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] HT_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] HS_C = CW'(H_SYNC);
  localparam logic [CW-1:0] VT_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] VS_C = CW'(V_SYNC);
  localparam logic [CW-1:0] HX0  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] HX1  = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VY0  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] VY1  = CW'(V_SYNC + V_BP + V_ACTIVE);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CMAX) ? x : x + CW'(1);
  endfunction

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  vga_mon_edge #(.POL(SYNC_POL)) u_hs (
    .clk_i(clk), .rst_i(rst), .sig_i(hs), .rise_o(hs_rise), .fall_o(hs_fall));
  vga_mon_edge #(.POL(SYNC_POL)) u_vs (
    .clk_i(clk), .rst_i(rst), .sig_i(vs), .rise_o(vs_rise), .fall_o(vs_fall));

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          vs_pend_q, vs_pend_d;
  logic [CW-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
  logic [CW-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic          de_q, de_d, fs_q;
  logic [7:0]    err_q;
  logic          hsat, geom_ok, lock_bad, err_inc;
  mon_state_e    state_q, state_d;

  // Counters and measurements for the cycle whose edges are visible now.
  // hcnt_d/vcnt_d are the position of the current normalised sample; a vs
  // edge is folded into the line count before a coincident hs edge restarts it.
  always_comb begin
    hcnt_d    = hs_rise ? '0 : sat_inc(hcnt_q);
    vcnt_d    = vcnt_q;
    vs_pend_d = vs_pend_q | vs_rise;
    if (hs_rise) begin
      vcnt_d    = (vs_rise || vs_pend_q) ? '0 : sat_inc(vcnt_q);
      vs_pend_d = 1'b0;
    end
    h_total_d  = hs_rise ? sat_inc(hcnt_q) : h_total_q;
    h_sync_w_d = hs_fall ? hcnt_d : h_sync_w_q;
    v_total_d  = vs_rise ? sat_inc(vcnt_q) : v_total_q;
    v_sync_w_d = vs_fall ? vcnt_d : v_sync_w_q;
    de_d       = (hcnt_d >= HX0) && (hcnt_d < HX1) && (vcnt_d >= VY0) && (vcnt_d < VY1);
    pix_x_d    = de_d ? hcnt_d - HX0 : '0;
    pix_y_d    = de_d ? vcnt_d - VY0 : '0;
  end

  // hsat fires once, on the cycle hcnt first pins at full scale (hs lost).
  assign hsat     = (hcnt_d == CMAX) && (hcnt_q != CMAX);
  assign geom_ok  = (h_total_d == HT_C) && (h_sync_w_d == HS_C) &&
                    (v_total_d == VT_C) && (v_sync_w_d == VS_C);
  assign lock_bad = hsat || (hs_rise && (h_total_d != HT_C)) ||
                    (vs_rise && ((v_total_d != VT_C) || (v_sync_w_d != VS_C)));

  // Measurement, counter and registered-output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      vs_pend_q  <= 1'b0;
      h_total_q  <= '0;
      h_sync_w_q <= '0;
      v_total_q  <= '0;
      v_sync_w_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      err_q      <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      vs_pend_q  <= vs_pend_d;
      h_total_q  <= h_total_d;
      h_sync_w_q <= h_sync_w_d;
      v_total_q  <= v_total_d;
      v_sync_w_q <= v_sync_w_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      de_q       <= de_d;
      fs_q       <= vs_rise;
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  // Lock FSM next state: one full frame must measure clean before LOCKED.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  if (vs_rise) state_d = MEASURE;
      MEASURE: if (vs_rise && geom_ok) state_d = LOCKED;
      LOCKED:  if (lock_bad) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Lock FSM outputs: lock flag and error-count strobe.
  always_comb begin
    locked  = (state_q == LOCKED);
    err_inc = 1'b0;
    unique case (state_q)
      MEASURE: err_inc = vs_rise && !geom_ok;
      LOCKED:  err_inc = lock_bad;
      default: err_inc = 1'b0;
    endcase
  end

  assign h_total     = h_total_q;
  assign h_sync_w    = h_sync_w_q;
  assign v_total     = v_total_q;
  assign v_sync_w    = v_sync_w_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign err_count   = err_q;

`ifdef VGA_MON_CRC_EN
  logic [11:0] rgb1_q, rgb2_q;
  logic [15:0] crc_q, fcrc_q;

  // Running CRC over active pixels; latched and reseeded at each frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb1_q <= '0;
      rgb2_q <= '0;
      crc_q  <= CRC_SEED;
      fcrc_q <= '0;
    end else begin
      rgb1_q <= {r, g, b};
      rgb2_q <= rgb1_q;
      if (vs_rise) begin
        fcrc_q <= crc_q;
        crc_q  <= CRC_SEED;
      end else if (de_d) begin
        crc_q  <= crc16_12(crc_q, rgb2_q);
      end
    end
  end

  assign frame_crc = fcrc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{r, g, b};
  assign frame_crc  = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor on a reduced 40x20 mode.
module tb_vga_timing_monitor;

  localparam int HT = 40, HS = 4, HBP = 6, HA = 24;
  localparam int VT = 20, VS = 2, VBP = 3, VA = 12;

  logic        clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic [10:0] h_total, h_sync_w, v_total, v_sync_w, pix_x, pix_y;
  logic        de, frame_start, locked;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
    .SYNC_POL(1'b1), .CW(11)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .pix_x(pix_x), .pix_y(pix_y), .de(de), .frame_start(frame_start),
    .locked(locked), .err_count(err_count), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] x;
    logic fb;
    x = c;
    for (int i = 11; i >= 0; i--) begin
      fb = d[i] ^ x[15];
      x  = x << 1;
      if (fb) x = x ^ 16'h1021;
    end
    return x;
  endfunction

  typedef struct {
    bit          geom;
    int          ht, hsw, vt, vsw;
    bit          lk;
    int          err;
    int          de_cnt;
    logic [15:0] crc;
  } exp_t;

  exp_t q[$];
  logic [15:0] model_crc = 16'hFFFF;
  int drv_first_cyc = 0, short_cyc = 0;

  // Expected state at the frame_start that opens the next driven frame.
  task automatic push(input bit geom, input int ht, input int hsw, input int vt,
                      input int vsw, input bit lk, input int err);
    exp_t e;
    e.geom = geom; e.ht = ht; e.hsw = hsw; e.vt = vt; e.vsw = vsw;
    e.lk = lk; e.err = err; e.de_cnt = HA * VA;
`ifdef VGA_MON_CRC_EN
    e.crc = model_crc;
`else
    e.crc = 16'h0000;
`endif
    model_crc = 16'hFFFF;
    q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_h_total"},  h_total, 0);
    chk({tag, "_h_sync_w"}, h_sync_w, 0);
    chk({tag, "_v_total"},  v_total, 0);
    chk({tag, "_v_sync_w"}, v_sync_w, 0);
    chk({tag, "_pix"},      {pix_x, pix_y}, 0);
    chk({tag, "_de_fs"},    {de, frame_start}, 0);
    chk({tag, "_locked"},   locked, 0);
    chk({tag, "_err"},      err_count, 0);
    chk({tag, "_crc"},      frame_crc, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b0; vs = 1'b0; {r, g, b} = 12'h000;
    end
  endtask

  task automatic drive_frame(input int short_line, input int rst_line, input logic [11:0] col);
    logic act;
    for (int v = 0; v < VT; v++) begin
      int hlen;
      hlen = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < hlen; h++) begin
        @(negedge clk);
        rst = (v == rst_line) && (h >= 15) && (h < 19);
        hs  = (h < HS);
        vs  = (v < VS);
        act = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
        {r, g, b} = act ? col : 12'h000;
        if (act) model_crc = crc_model(model_crc, col);
        if (h == HS + HBP && v == VS + VBP) drv_first_cyc = cyc;
        if (short_line >= 0 && v == short_line + 1 && h == 0) short_cyc = cyc;
        if (v == rst_line && h == 17) chk_zero("mid_rst");
      end
    end
  endtask

  // Monitor: scoreboard at frame_start, pixel-stream and lock-drop tracking.
  int  de_cnt = 0, px = 0, py = 0, drops = 0, first_drop_cyc = -1;
  bit  pde = 0, frame_first = 1, seen_fs = 0, plk = 0;
  exp_t e_m;

  always @(negedge clk) begin
    if (plk && !locked) begin
      drops++;
      if (first_drop_cyc < 0) first_drop_cyc = cyc;
    end
    plk = locked;
    if (rst) begin
      de_cnt = 0; pde = 0; frame_first = 1; seen_fs = 0;
    end else begin
      if (frame_start) begin
        if (q.size() == 0) begin
          chk("fs_unexpected", 1, 0);
        end else begin
          e_m = q.pop_front();
          chk("fs_locked", locked, e_m.lk);
          chk("fs_err_count", err_count, e_m.err);
          if (e_m.geom) begin
            chk("fs_h_total",  h_total,  e_m.ht);
            chk("fs_h_sync_w", h_sync_w, e_m.hsw);
            chk("fs_v_total",  v_total,  e_m.vt);
            chk("fs_v_sync_w", v_sync_w, e_m.vsw);
            chk("fs_de_count", de_cnt,   e_m.de_cnt);
            chk("fs_last_row", py,       VA - 1);
            chk("fs_frame_crc", frame_crc, e_m.crc);
          end
        end
        de_cnt = 0; frame_first = 1; seen_fs = 1;
      end
      if (de) begin
        de_cnt++;
        if (!pde) begin
          chk("line_first_x", pix_x, 0);
          chk("line_y", pix_y, frame_first ? 0 : py + 1);
          if (frame_first && seen_fs) chk("de_latency", cyc - drv_first_cyc, 3);
          frame_first = 0;
        end else begin
          chk("x_step", pix_x, px + 1);
          chk("y_hold", pix_y, py);
        end
        px = pix_x; py = pix_y;
      end else begin
        if (pde) chk("line_last_x", px, HA - 1);
        chk("pix_idle_zero", {pix_x, pix_y}, 0);
      end
      pde = de;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(10);
    push(0,    0, 0,  0, 0, 0, 0); drive_frame(-1, -1, 12'hFFF); // F1: acquire
    push(1,   40, 4, 20, 2, 1, 0); drive_frame(-1, -1, 12'h000); // F2: locked
    push(1,   40, 4, 20, 2, 1, 0); drive_frame( 8, -1, 12'hFFF); // F3: short line 8
    push(1,   40, 4, 20, 2, 0, 1); drive_frame(-1, -1, 12'hFFF); // F4: measuring
    push(1,   40, 4, 20, 2, 1, 1); drive_frame(-1, -1, 12'h000); // F5: relocked
    idle(2100);                                                   // hs lost
    push(1, 2047, 4, 20, 2, 0, 2); drive_frame(-1, -1, 12'hFFF); // F6: saturated
    push(1,   40, 4, 20, 2, 1, 2); drive_frame(-1, 10, 12'hFFF); // F7: reset mid-frame
    push(0,    0, 0,  0, 0, 0, 0); drive_frame(-1, -1, 12'hFFF); // F8
    push(1,   40, 4, 20, 2, 1, 0); drive_frame(-1, -1, 12'hFFF); // F9
    push(1,   40, 4, 20, 2, 1, 0); drive_frame(-1, -1, 12'h000); // F10
    idle(30);
    chk("fs_all_seen", q.size(), 0);
    chk("lock_drops", drops, 3);
    chk("drop_latency", first_drop_cyc - short_cyc, 3);
    chk("final_locked", locked, 1);
    chk("final_err", err_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side counterpart of the VGA timing generator.
- Consumes hs/vs/r/g/b, as driven into the frame-capture model, and measures the line and frame geometry.
- Checks that geometry against the expected mode (800x600@60, 1056x628 total) and recovers the pixel coordinate and data-enable.
- Sits beside vga_example in synthesis as a self-check; its status is also readable in simulation.

Parameters:
H_TOTAL, 1056, expected clocks per line
H_SYNC, 128, expected hs active width, clocks
H_BP, 88, hs inactive clocks before the first active pixel
H_ACTIVE, 800, active pixels per line
V_TOTAL, 628, expected lines per frame
V_SYNC, 4, expected vs active width, lines
V_BP, 23, lines after vs before the first active line
V_ACTIVE, 600, active lines per frame
SYNC_POL, 1, 1 = syncs active-high, 0 = active-low
CW, 11, counter width; saturates at 2^CW-1

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
hs  in  1  horizontal sync under test
vs  in  1  vertical sync under test
r  in  4  red
g  in  4  green
b  in  4  blue
h_total  out  CW  last measured clocks between hs active edges
h_sync_w  out  CW  last measured hs active width
v_total  out  CW  last measured lines between vs active edges
v_sync_w  out  CW  last measured vs active width, lines
pix_x  out  CW  recovered x; valid when de=1
pix_y  out  CW  recovered y; valid when de=1
de  out  1  recovered active-video enable
frame_start  out  1  1-clk pulse on each vs active edge
locked  out  1  geometry matches parameters
err_count  out  8  saturating mismatch counter
frame_crc  out  16  see Optional Feature

Behaviour:
- Reset: every output is 0, and all internal counters and the FSM (SEARCH) are cleared, asynchronously.
- Input register stage:
  - hs/vs/rgb are registered twice, then XORed with ~SYNC_POL to normalise to active-high.
  - An edge is a 0->1 transition of the normalised second stage.
  - Total input-to-output latency is 3 clocks.
- hcnt:
  - Resets to 0 on the hs edge cycle, otherwise increments.
  - Saturates at 2^CW-1; it never wraps.
  - On each hs edge, h_total <= hcnt+1 (saturating).
  - On the hs falling edge, h_sync_w <= clocks hs was active.
- vcnt:
  - Increments on each hs edge and is set to 0 on an hs edge coincident with, or following, a vs edge.
  - On a vs edge: v_total <= lines counted, and v_sync_w is captured at the vs falling edge in lines.
  - vs and hs edges in the same cycle: the vs edge is processed first, then that hs edge starts line 0.
- de = (hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE)) && (vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)).
  - pix_x = hcnt-(H_SYNC+H_BP) and pix_y = vcnt-(V_SYNC+V_BP), registered.
  - pix_x/pix_y hold 0 when de=0.
- frame_start is a single pulse, registered alongside de.
- FSM:
  - SEARCH: wait for the first vs edge -> MEASURE.
  - MEASURE: at the next vs edge, compare v_total, v_sync_w, and the h_total/h_sync_w of the last full line against the parameters. All equal -> LOCKED. Any differ -> err_count+1 and stay in MEASURE.
  - LOCKED: locked=1. Every hs edge checks h_total and every vs edge checks v_total/v_sync_w. Any mismatch, or hcnt saturating (hs lost) -> err_count+1, locked=0 the next clock, -> SEARCH.
- err_count saturates at 255 and is cleared only by rst.
- Reset asserted mid-frame: everything clears immediately. After release, 2 vs edges are required before locked=1.

Optional Feature:
- Macro: VGA_MON_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over {r,g,b} (12 bits, r MSB-first) on every de=1 cycle.
  - On frame_start, frame_crc <= running CRC, then the running CRC is reseeded to 0xFFFF.
- Undefined: frame_crc is tied to 0 and no CRC logic is synthesised.

Decomposition:
- Package vga_mon_pkg holds:
  - mode constants (800x600 timing values as the parameter defaults);
  - FSM state encoding: SEARCH, MEASURE, LOCKED;
  - CRC polynomial and seed.
- One sub-module, vga_mon_edge: 2-flop sync, polarity normalise, rise/fall pulse. Instantiated for hs and vs.

Test Plan:
- Nominal 800x600 generator, 40 MHz-equivalent clk -> h_total=1056, h_sync_w=128, v_total=628, v_sync_w=4; locked=1 after the 2nd vs edge; err_count=0.
- Nominal stream, check pixel (0,0) and (799,599) -> de rises 3 clocks after the input hcnt=216 on line 27; pix_x=0, pix_y=0; de high exactly 800 clocks per line, 600 lines.
- While locked, one line shortened to 1055 clocks -> locked=0 one clock after that hs edge, err_count=1, relock after 2 further vs edges.
- hs held inactive for 2048+ clocks -> hcnt saturates, locked=0, err_count increments once, no wrap.
- rst pulsed 40 ns mid-frame -> all outputs 0 during reset; locked returns only after 2 vs edges.
- VGA_MON_CRC_EN with a constant colour 0xFFF frame -> frame_crc equals the precomputed reference; with 0x000 a different value; identical across consecutive frames.
